// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I-style decode stage (register file, immediate decode, load-use
// hazard detection, ID/EX pipeline register). Define ID_BYPASS_EN for WB->ID write-through reads.
module id_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            ex_stall,
    input  logic            flush,
    input  logic            wb_wr,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            if_id_write,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [AW-1:0]   ex_rs1,
    output logic [AW-1:0]   ex_rs2,
    output logic [AW-1:0]   ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [9:0]      ex_funct,
    output logic            ex_mem_read
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [XLEN-1:0] rf [NREGS];

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [6:0]      opcode;
    logic [9:0]      funct;
    logic            is_load;
    logic            byp1;
    logic            byp2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;
    logic            hazard;

    // Index bits above AW are dropped, so a smaller regfile aliases the upper names.
    assign rs1     = instr[15 +: AW];
    assign rs2     = instr[20 +: AW];
    assign rd      = instr[7 +: AW];
    assign opcode  = instr[6:0];
    assign funct   = {instr[31:25], instr[14:12]};
    assign is_load = (opcode == OP_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_wr && (wb_rd != '0)) begin
            rf[wb_rd] <= wb_data;
        end
    end

`ifdef ID_BYPASS_EN
    assign byp1 = wb_wr && (wb_rd == rs1);
    assign byp2 = wb_wr && (wb_rd == rs2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != '0) begin
            rs1_val = byp1 ? wb_data : rf[rs1];
        end
        if (rs2 != '0) begin
            rs2_val = byp2 ? wb_data : rf[rs2];
        end
    end

    always_comb begin
        imm32 = '0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm32 = {instr[31:12], 12'b0};
            OP_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm_x = XLEN'(signed'(imm32));

    // rs2 is compared even for formats without an rs2 field; a spurious stall is harmless.
    assign hazard = ex_valid & ex_mem_read & id_valid & (ex_rd != '0) &
                    ((ex_rd == rs1) | (ex_rd == rs2));

    assign if_id_write = ~ex_stall & ~(hazard & ~flush);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct    <= '0;
            ex_mem_read <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (!ex_stall) begin
            if (hazard) begin
                ex_valid    <= 1'b0;
                ex_mem_read <= 1'b0;
            end else begin
                ex_valid    <= id_valid;
                ex_pc       <= pc_in;
                ex_rs1_data <= rs1_val;
                ex_rs2_data <= rs2_val;
                ex_imm      <= imm_x;
                ex_rs1      <= rs1;
                ex_rs2      <= rs2;
                ex_rd       <= rd;
                ex_opcode   <= opcode;
                ex_funct    <= funct;
                ex_mem_read <= is_load & id_valid;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed scenarios plus randomized traffic for id_stage_pipe,
// checked against an instruction-level reference model of the decode stage.
module tb_id_stage_pipe;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc_in;
    logic            ex_stall;
    logic            flush;
    logic            wb_wr;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            if_id_write;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [AW-1:0]   ex_rs1;
    logic [AW-1:0]   ex_rs2;
    logic [AW-1:0]   ex_rd;
    logic [6:0]      ex_opcode;
    logic [9:0]      ex_funct;
    logic            ex_mem_read;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr), .pc_in(pc_in),
        .ex_stall(ex_stall), .flush(flush), .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .if_id_write(if_id_write), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
        .ex_funct(ex_funct), .ex_mem_read(ex_mem_read)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: architectural register values and the instruction sitting in EX.
    logic [31:0] mrf [32];
    logic        m_valid;
    logic [31:0] m_pc, m_a, m_b, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [6:0]  m_op;
    logic [9:0]  m_funct;
    logic        m_mrd;
    logic        exp_ifw;
    logic        obs_ifw;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mrf[i] = '0;
        m_valid = 0; m_pc = 0; m_a = 0; m_b = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0; m_funct = 0; m_mrd = 0;
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] iw);
        int sx;
        sx = signed'(iw);
        case (iw[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                return 32'(sx >>> 20);
            7'b0100011:
                return 32'((sx >>> 25) * 32) | 32'(iw[11:7]);
            7'b1100011:
                return 32'((sx >>> 31) * 4096) | (32'(iw[7]) << 11) |
                       (32'(iw[30:25]) << 5) | (32'(iw[11:8]) << 1);
            7'b0110111, 7'b0010111:
                return iw & 32'hFFFF_F000;
            7'b1101111:
                return 32'((sx >>> 31) * 1048576) | (32'(iw[19:12]) << 12) |
                       (32'(iw[20]) << 11) | (32'(iw[30:21]) << 1);
            default:
                return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef ID_BYPASS_EN
        if (wb_wr && wb_rd == idx) return wb_data;
`endif
        return mrf[idx];
    endfunction

    function automatic logic ref_load_use();
        logic [4:0] s1;
        logic [4:0] s2;
        s1 = instr[19:15];
        s2 = instr[24:20];
        return m_valid && m_mrd && id_valid && (m_rd != 5'd0) && (m_rd == s1 || m_rd == s2);
    endfunction

    task automatic model_step();
        logic hz;
        hz = ref_load_use();
        if (flush) begin
            m_valid = 0;
        end else if (!ex_stall) begin
            if (hz) begin
                m_valid = 0;
                m_mrd   = 0;
            end else begin
                m_valid = id_valid;
                m_pc    = pc_in;
                m_a     = ref_read(instr[19:15]);
                m_b     = ref_read(instr[24:20]);
                m_imm   = ref_imm(instr);
                m_rs1   = instr[19:15];
                m_rs2   = instr[24:20];
                m_rd    = instr[11:7];
                m_op    = instr[6:0];
                m_funct = {instr[31:25], instr[14:12]};
                m_mrd   = id_valid && (instr[6:0] == 7'b0000011);
            end
        end
        if (wb_wr && wb_rd != 5'd0) mrf[wb_rd] = wb_data;
    endtask

    task automatic check_idex();
        check_val("ex_valid", 32'(ex_valid), 32'(m_valid));
        if (m_valid) begin
            check_val("ex_pc", ex_pc, m_pc);
            check_val("ex_rs1_data", ex_rs1_data, m_a);
            check_val("ex_rs2_data", ex_rs2_data, m_b);
            check_val("ex_imm", ex_imm, m_imm);
            check_val("ex_rs1", 32'(ex_rs1), 32'(m_rs1));
            check_val("ex_rs2", 32'(ex_rs2), 32'(m_rs2));
            check_val("ex_rd", 32'(ex_rd), 32'(m_rd));
            check_val("ex_opcode", 32'(ex_opcode), 32'(m_op));
            check_val("ex_funct", 32'(ex_funct), 32'(m_funct));
            check_val("ex_mem_read", 32'(ex_mem_read), 32'(m_mrd));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        exp_ifw = !ex_stall && !(ref_load_use() && !flush);
        obs_ifw = if_id_write;
        check_val("if_id_write", 32'(obs_ifw), 32'(exp_ifw));
        @(posedge clk);
        model_step();
        #1;
        check_idex();
    endtask

    task automatic set_idle();
        id_valid = 0; instr = 32'h0000_0013; pc_in = 0;
        ex_stall = 0; flush = 0; wb_wr = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic drive(input logic [31:0] iw, input logic [31:0] pc);
        id_valid = 1; instr = iw; pc_in = pc;
    endtask

    logic [6:0] ops [11] = '{7'b0000011, 7'b0000011, 7'b0000011, 7'b0010011, 7'b1100111,
                             7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                             7'b1101111};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0;
        set_idle();
        model_reset();
        exp_ifw = 1;
        obs_ifw = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        check_val("rst_ex_valid", 32'(ex_valid), 32'h0);
        check_val("rst_ex_pc", ex_pc, 32'h0);
        check_val("rst_ex_imm", ex_imm, 32'h0);
        check_val("rst_if_id_write", 32'(if_id_write), 32'h1);

        // WB x5 then read it back through decode
        wb_wr = 1; wb_rd = 5; wb_data = 32'hDEAD_BEEF;
        cycle();
        wb_wr = 0;
        drive(32'h0002_80B3, 32'h100);
        cycle();
        check_val("t2_rs1_data", ex_rs1_data, 32'hDEAD_BEEF);
        check_val("t2_rs2_data", ex_rs2_data, 32'h0);

        // same-cycle write and read of x7
        id_valid = 0;
        wb_wr = 1; wb_rd = 7; wb_data = 32'h5555;
        cycle();
        drive(32'h0073_80B3, 32'h104);
        wb_wr = 1; wb_rd = 7; wb_data = 32'h1234;
        cycle();
        wb_wr = 0;
`ifdef ID_BYPASS_EN
        check_val("t3_rs1_data", ex_rs1_data, 32'h1234);
        check_val("t3_rs2_data", ex_rs2_data, 32'h1234);
`else
        check_val("t3_rs1_data", ex_rs1_data, 32'h5555);
        check_val("t3_rs2_data", ex_rs2_data, 32'h5555);
`endif

        // load-use: one stall cycle, one bubble, then the add enters EX
        drive(32'h0001_2183, 32'h108);
        cycle();
        check_val("t4_lw_mem_read", 32'(ex_mem_read), 32'h1);
        drive(32'h0011_8233, 32'h10C);
        cycle();
        check_val("t4_stall_ifw", 32'(obs_ifw), 32'h0);
        check_val("t4_bubble", 32'(ex_valid), 32'h0);
        cycle();
        check_val("t4_retry_ifw", 32'(obs_ifw), 32'h1);
        check_val("t4_add_valid", 32'(ex_valid), 32'h1);
        check_val("t4_add_rs1", 32'(ex_rs1), 32'h3);
        check_val("t4_add_pc", ex_pc, 32'h10C);

        // flush overrides an active hazard; x0 ignores writes
        drive(32'h0001_2183, 32'h110);
        cycle();
        drive(32'h0011_8233, 32'h114);
        flush = 1;
        cycle();
        flush = 0;
        check_val("t5_flush_ifw", 32'(obs_ifw), 32'h1);
        check_val("t5_flush_valid", 32'(ex_valid), 32'h0);
        id_valid = 0;
        wb_wr = 1; wb_rd = 0; wb_data = 32'hFFFF;
        cycle();
        wb_wr = 0;
        drive(32'h0000_00B3, 32'h118);
        cycle();
        check_val("t5_x0_rs1", ex_rs1_data, 32'h0);
        check_val("t5_x0_rs2", ex_rs2_data, 32'h0);

        // immediates
        drive(32'hFE00_0EE3, 32'h11C);
        cycle();
        check_val("t6_beq_imm", ex_imm, 32'hFFFF_FFFC);
        drive(32'h8000_00B7, 32'h120);
        cycle();
        check_val("t6_lui_imm", ex_imm, 32'h8000_0000);

        // asynchronous reset mid-stream
        drive(32'h0002_80B3, 32'h124);
        cycle();
        check_val("t1_pre_rs1", ex_rs1_data, 32'hDEAD_BEEF);
        rst = 0;
        #1;
        check_val("t1_async_valid", 32'(ex_valid), 32'h0);
        check_val("t1_async_rs1", ex_rs1_data, 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1;
        drive(32'h0072_80B3, 32'h128);
        cycle();
        check_val("t1_post_rs1", ex_rs1_data, 32'h0);
        check_val("t1_post_rs2", ex_rs2_data, 32'h0);

        // randomized traffic; upstream holds IF/ID whenever if_id_write is low
        for (int n = 0; n < 1500; n++) begin
            if (exp_ifw) begin
                logic [31:0] iw;
                iw = $urandom;
                iw[6:0] = ($urandom_range(0, 11) == 11) ? 7'($urandom) : ops[$urandom_range(0, 10)];
                iw[19:15] = 5'($urandom_range(0, 7));
                iw[24:20] = 5'($urandom_range(0, 7));
                iw[11:7]  = 5'($urandom_range(0, 7));
                instr = iw;
                pc_in = $urandom;
                id_valid = ($urandom_range(0, 9) < 8);
            end
            ex_stall = ($urandom_range(0, 9) < 2);
            flush    = ($urandom_range(0, 9) == 0);
            wb_wr    = $urandom_range(0, 1) == 1;
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
